// File: rtl/dmem_arb_pkg.sv
// Shared types and funct3 size/sign codes for the data-memory arbiter
// and the blocks that talk to it.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle of dmem_arbiter; the arbiter
// uses the slave modport, the environment (requesters + memory) the master.
interface dmem_arb_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     p0_req;
    logic                     p0_we;
    logic [ADDRESS_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0]    p0_wdata;
    logic [2:0]               p0_funct3;
    logic                     p0_gnt;
    logic                     p0_done;
    logic [DATA_WIDTH-1:0]    p0_rdata;

    logic                     p1_req;
    logic                     p1_we;
    logic [ADDRESS_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0]    p1_wdata;
    logic [2:0]               p1_funct3;
    logic                     p1_gnt;
    logic                     p1_done;
    logic [DATA_WIDTH-1:0]    p1_rdata;

    logic                     mem_wr_en;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [2:0]               mem_funct3;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     busy;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
        output mem_rdata,
        input  p0_gnt, p0_done, p0_rdata, p1_gnt, p1_done, p1_rdata,
        input  mem_wr_en, mem_addr, mem_wdata, mem_funct3, busy
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
        input  mem_rdata,
        output p0_gnt, p0_done, p0_rdata, p1_gnt, p1_done, p1_rdata,
        output mem_wr_en, mem_addr, mem_wdata, mem_funct3, busy
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational two-way winner select: on a tie the requester that was
// not granted last wins; a single request always wins.
module dmem_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic valid,
    output logic id
);

    // winner decode
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            id = ~last_gnt;
        end else if (req1) begin
            id = 1'b1;
        end else begin
            id = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> RESP per access.
// Define DMEM_ARB_RR_EN for round-robin ties; default build is fixed priority (p0 wins).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic        clk,
    input  logic        rst,
    dmem_arb_if.slave   bus
);

    arb_state_t               state_r;
    logic                     cmd_id_r;
    logic                     cmd_we_r;
    logic [ADDRESS_WIDTH-1:0] cmd_addr_r;
    logic [DATA_WIDTH-1:0]    cmd_wdata_r;
    logic [2:0]               cmd_funct3_r;
    logic [DATA_WIDTH-1:0]    rdata_r;

    logic last_gnt_s;
    logic pick_valid_s;
    logic pick_id_s;

`ifdef DMEM_ARB_RR_EN
    logic last_gnt_r;

    // round-robin pointer: remembers the id granted on every exit from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_r <= 1'b1;
        end else if ((state_r == IDLE) && pick_valid_s) begin
            last_gnt_r <= pick_id_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    assign last_gnt_s = last_gnt_r;
`else
    assign last_gnt_s = 1'b1;
`endif

    dmem_rr_pick u_pick (
        .req0     (bus.p0_req),
        .req1     (bus.p1_req),
        .last_gnt (last_gnt_s),
        .valid    (pick_valid_s),
        .id       (pick_id_s)
    );

    // sequencer FSM, command latch and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cmd_id_r     <= 1'b0;
            cmd_we_r     <= 1'b0;
            cmd_addr_r   <= {ADDRESS_WIDTH{1'b0}};
            cmd_wdata_r  <= {DATA_WIDTH{1'b0}};
            cmd_funct3_r <= 3'b000;
            rdata_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        state_r      <= ACCESS;
                        cmd_id_r     <= pick_id_s;
                        cmd_we_r     <= pick_id_s ? bus.p1_we     : bus.p0_we;
                        cmd_addr_r   <= pick_id_s ? bus.p1_addr   : bus.p0_addr;
                        cmd_wdata_r  <= pick_id_s ? bus.p1_wdata  : bus.p0_wdata;
                        cmd_funct3_r <= pick_id_s ? bus.p1_funct3 : bus.p0_funct3;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // stores return zero so a stale load value never leaks out
                    rdata_r <= cmd_we_r ? {DATA_WIDTH{1'b0}} : bus.mem_rdata;
                    state_r <= RESP;
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // output decode from state and command registers; rst gates the write strobe
    always_comb begin
        bus.p0_gnt     = 1'b0;
        bus.p1_gnt     = 1'b0;
        bus.p0_done    = 1'b0;
        bus.p1_done    = 1'b0;
        bus.p0_rdata   = {DATA_WIDTH{1'b0}};
        bus.p1_rdata   = {DATA_WIDTH{1'b0}};
        bus.mem_wr_en  = 1'b0;
        bus.mem_addr   = {ADDRESS_WIDTH{1'b0}};
        bus.mem_wdata  = {DATA_WIDTH{1'b0}};
        bus.mem_funct3 = 3'b000;
        case (state_r)
            ACCESS: begin
                bus.p0_gnt     = ~cmd_id_r;
                bus.p1_gnt     = cmd_id_r;
                bus.mem_wr_en  = cmd_we_r & ~rst;
                bus.mem_addr   = cmd_addr_r;
                bus.mem_wdata  = cmd_wdata_r;
                bus.mem_funct3 = cmd_funct3_r;
            end
            RESP: begin
                bus.p0_done = ~cmd_id_r;
                bus.p1_done = cmd_id_r;
                if (cmd_id_r) begin
                    bus.p1_rdata = rdata_r;
                end else begin
                    bus.p0_rdata = rdata_r;
                end
            end
            default: begin
            end
        endcase
        bus.busy = (state_r != IDLE);
    end

endmodule
